decode_stage_param: RTL
=======================

# decode_stage_param

Parametrised instruction-decode stage for the pipelined MIPS core. It holds the architectural register file, with same-cycle write-through bypass and a hardwired zero register. It resolves BEQ/BNE in decode, using forwarded compare operands. It drives the ID/EX pipeline register with valid tracking, stall-bubble insertion and flush. It sits between the IF/ID register and the execute stage, and accepts write-back traffic from the WB stage.

## Interface
Parameters:
- DATA_W, 32, datapath width: register file, PC, immediate and compare operands.
- CTRL_W, 8, width of the opaque control bundle produced by the control unit.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- if_id_instr  in  32  instruction word from IF/ID.
- if_id_pc4  in  DATA_W  PC+4 from IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- ctrl_in  in  CTRL_W  control bundle for the current instruction.
- is_beq / is_bne  in  1 each  branch type of the current instruction.
- stall  in  1  from hazard unit: inject a bubble into ID/EX.
- flush  in  1  clear ID/EX.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back destination.
- wb_data  in  DATA_W  write-back data.
- exmem_alu  in  DATA_W  EX/MEM ALU result, used for branch forwarding.
- cmp_sel1 / cmp_sel2  in  2 each  compare-operand select.
- if_id_rs / if_id_rt  out  5 each  instr[25:21] and instr[20:16], combinational, for the hazard unit.
- branch_taken  out  1  combinational branch decision.
- branch_target  out  DATA_W  combinational branch target.
- id_ex_valid, id_ex_ctrl[CTRL_W], id_ex_rd1[DATA_W], id_ex_rd2[DATA_W], id_ex_rs[5], id_ex_rt[5], id_ex_rd[5], id_ex_shamt[5], id_ex_funct[6], id_ex_imm[DATA_W], id_ex_pc4[DATA_W]  out  registered ID/EX contents.

## Operation
Register file:
- 32 entries of DATA_W bits.
- Write on the clk rising edge when wb_we=1. The write is suppressed when ZERO_REG=1 and wb_addr=0.
- Reads are combinational on rs and rt.
- Bypass: if wb_we=1, wb_addr equals the read address, and the write is not suppressed, the read returns wb_data rather than the stored value.
- With ZERO_REG=1, reads of address 0 return 0.

Immediate and branch target:
- imm = sign-extension of instr[15:0] to DATA_W.
- branch_target = if_id_pc4 + (imm << 2), computed modulo 2^DATA_W with wrap-around and no overflow flag.

Branch compare:
- Operand select: sel 0 = bypassed regfile read, 1 = exmem_alu, 2 = wb_data, 3 = regfile read (same as 0).
- eq = (op1 == op2).
- branch_taken = if_id_valid & ~stall & ~rst & ((is_beq & eq) | (is_bne & ~eq)).
- If is_beq and is_bne are both 1, branch_taken is 1 whenever if_id_valid & ~stall & ~rst.

ID/EX register update on each rising edge, in priority order:
1. rst: every id_ex_* output and every register file entry is set to 0. A write pending in the same cycle is discarded.
2. flush: every id_ex_* output is set to 0. The register file write still occurs.
3. stall: id_ex_valid and id_ex_ctrl are set to 0. The datapath fields still load, so their contents are don't-care for the bubble.
4. Otherwise: all fields load. id_ex_valid = if_id_valid, id_ex_ctrl = ctrl_in, id_ex_rd1 and id_ex_rd2 take the bypassed reads, id_ex_rs/rt/rd/shamt/funct take their instruction fields, id_ex_imm = imm, id_ex_pc4 = if_id_pc4.

- When if_id_valid=0, id_ex_ctrl is forced to 0, in the same way as a bubble.
- The block has no internal stall counter. The hazard unit holds IF/ID during a stall, and this block only bubbles ID/EX.

## Timing
- Decode-to-ID/EX latency: 1 cycle.
- branch_taken and branch_target are valid in the same cycle as the IF/ID inputs. The fetch stage samples them on the next edge.
- A write-back and a dependent read in the same cycle yield the new data, giving zero-cycle RAW through the register file.
- Reset values: all id_ex_* outputs = 0; all registers = 0. branch_taken = 0 while rst is high.
- Reset asserted mid-stream: the cycle after it deasserts, ID/EX outputs 0 until the next edge. Nothing from before the reset survives.
- flush and stall asserted together: the result is identical to flush alone.

## Test plan
- Reset: load r5=0x1234, then assert rst for 1 cycle → the next cycle all id_ex_* = 0 and a read of r5 returns 0.
- Bypass: wb_we=1, wb_addr=7, wb_data=0xDEADBEEF, instr rs=7 in the same cycle → id_ex_rd1=0xDEADBEEF after the edge; r7 holds it afterwards.
- Zero register: ZERO_REG=1, write 0xFFFF_FFFF to r0, then read rs=0 → 0. Repeat with ZERO_REG=0 → 0xFFFF_FFFF.
- Branch forwarding: r1=5, r2=9, exmem_alu=9, cmp_sel1=1, is_beq=1, pc4=0x100, imm=0xFFFE → branch_taken=1, branch_target=0xF8. With cmp_sel1=0 → branch_taken=0. With is_bne=1 instead → branch_taken=1.
- Stall/flush: ctrl_in=0xA5 with stall=1 → id_ex_ctrl=0 and id_ex_valid=0. flush=1 → all id_ex_* = 0. stall and flush both 1 → result equals flush alone.
- Sign extension: imm=0x8000 → id_ex_imm=0xFFFF8000. imm=0x7FFF → 0x00007FFF.

Source files
------------

// File: rtl/decode_stage_param_if.sv
// Bundle between the IF/ID register, hazard/control units, WB stage and the
// decode stage. The decode stage uses the slave view; its environment uses master.
interface decode_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic [31:0]       if_id_instr;
  logic [DATA_W-1:0] if_id_pc4;
  logic              if_id_valid;
  logic [CTRL_W-1:0] ctrl_in;
  logic              is_beq;
  logic              is_bne;
  logic              stall;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] exmem_alu;
  logic [1:0]        cmp_sel1;
  logic [1:0]        cmp_sel2;

  logic [4:0]        if_id_rs;
  logic [4:0]        if_id_rt;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;

  logic              id_ex_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [DATA_W-1:0] id_ex_rd1;
  logic [DATA_W-1:0] id_ex_rd2;
  logic [4:0]        id_ex_rs;
  logic [4:0]        id_ex_rt;
  logic [4:0]        id_ex_rd;
  logic [4:0]        id_ex_shamt;
  logic [5:0]        id_ex_funct;
  logic [DATA_W-1:0] id_ex_imm;
  logic [DATA_W-1:0] id_ex_pc4;

  modport master (
    output if_id_instr, if_id_pc4, if_id_valid, ctrl_in, is_beq, is_bne,
           stall, flush, wb_we, wb_addr, wb_data, exmem_alu, cmp_sel1, cmp_sel2,
    input  if_id_rs, if_id_rt, branch_taken, branch_target,
           id_ex_valid, id_ex_ctrl, id_ex_rd1, id_ex_rd2, id_ex_rs, id_ex_rt,
           id_ex_rd, id_ex_shamt, id_ex_funct, id_ex_imm, id_ex_pc4
  );

  modport slave (
    input  if_id_instr, if_id_pc4, if_id_valid, ctrl_in, is_beq, is_bne,
           stall, flush, wb_we, wb_addr, wb_data, exmem_alu, cmp_sel1, cmp_sel2,
    output if_id_rs, if_id_rt, branch_taken, branch_target,
           id_ex_valid, id_ex_ctrl, id_ex_rd1, id_ex_rd2, id_ex_rs, id_ex_rt,
           id_ex_rd, id_ex_shamt, id_ex_funct, id_ex_imm, id_ex_pc4
  );
endinterface

// File: rtl/decode_stage_param.sv
// MIPS decode stage: register file with write-through bypass, BEQ/BNE resolved
// in decode with forwarded operands, and the ID/EX register (bubble/flush).
module decode_stage_param #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 8,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  decode_stage_param_if.slave bus
);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [32];
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] op1, op2;
  logic              wr_en;
  logic              eq;
  logic              issue;

  assign rs    = bus.if_id_instr[25:21];
  assign rt    = bus.if_id_instr[20:16];
  assign rd    = bus.if_id_instr[15:11];
  assign shamt = bus.if_id_instr[10:6];
  assign funct = bus.if_id_instr[5:0];
  assign imm   = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

  assign bus.if_id_rs = rs;
  assign bus.if_id_rt = rt;

  // A write to the hardwired zero register is dropped, so it must not bypass either.
  assign wr_en = bus.wb_we && !(HAS_ZERO && (bus.wb_addr == 5'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rd1 = regs[rs];
    if (HAS_ZERO && (rs == 5'd0))        rd1 = '0;
    else if (wr_en && (bus.wb_addr == rs)) rd1 = bus.wb_data;
  end

  always_comb begin
    rd2 = regs[rt];
    if (HAS_ZERO && (rt == 5'd0))        rd2 = '0;
    else if (wr_en && (bus.wb_addr == rt)) rd2 = bus.wb_data;
  end

  always_comb begin
    case (bus.cmp_sel1)
      2'd1:    op1 = bus.exmem_alu;
      2'd2:    op1 = bus.wb_data;
      default: op1 = rd1;
    endcase
    case (bus.cmp_sel2)
      2'd1:    op2 = bus.exmem_alu;
      2'd2:    op2 = bus.wb_data;
      default: op2 = rd2;
    endcase
  end

  assign eq    = (op1 == op2);
  assign issue = bus.if_id_valid && !bus.stall;

  // BEQ and BNE together cover both outcomes, so that case always redirects.
  assign bus.branch_taken  = issue && !rst &&
                             ((bus.is_beq && eq) || (bus.is_bne && !eq));
  assign bus.branch_target = bus.if_id_pc4 + (imm << 2);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.id_ex_valid <= 1'b0;
      bus.id_ex_ctrl  <= '0;
      bus.id_ex_rd1   <= '0;
      bus.id_ex_rd2   <= '0;
      bus.id_ex_rs    <= '0;
      bus.id_ex_rt    <= '0;
      bus.id_ex_rd    <= '0;
      bus.id_ex_shamt <= '0;
      bus.id_ex_funct <= '0;
      bus.id_ex_imm   <= '0;
      bus.id_ex_pc4   <= '0;
    end else begin
      // Bubbles (stall or empty IF/ID) clear only valid and control.
      bus.id_ex_valid <= issue;
      bus.id_ex_ctrl  <= issue ? bus.ctrl_in : '0;
      bus.id_ex_rd1   <= rd1;
      bus.id_ex_rd2   <= rd2;
      bus.id_ex_rs    <= rs;
      bus.id_ex_rt    <= rt;
      bus.id_ex_rd    <= rd;
      bus.id_ex_shamt <= shamt;
      bus.id_ex_funct <= funct;
      bus.id_ex_imm   <= imm;
      bus.id_ex_pc4   <= bus.if_id_pc4;
    end
  end
endmodule
